// File: rtl/io_seq_ctrl_if.sv
// io_seq_ctrl_if
// Groups every core-side and pad-side signal of the pad sequencer.
//   slave  : the sequencer's view (core requests and host quarters in, strobes out)
//   master : the core/pad environment's view (the opposite directions)
// Core side : gray_req, gray_addr, gray_ready, gray_data,
//             lbp_valid, lbp_addr, lbp_data, lbp_ack, finish_in
// Pad side  : gray_addr_hold, lbp_addr_hold, lbp_data_hold, gray_count, lbp_count,
//             gray_req_pad, gray_data_qtr, lbp_valid_pad, finish
interface io_seq_ctrl_if;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic        gray_ready;
    logic [7:0]  gray_data;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        lbp_ack;
    logic        finish_in;
    logic [13:0] gray_addr_hold;
    logic [13:0] lbp_addr_hold;
    logic [7:0]  lbp_data_hold;
    logic [1:0]  gray_count;
    logic [1:0]  lbp_count;
    logic        gray_req_pad;
    logic [1:0]  gray_data_qtr;
    logic        lbp_valid_pad;
    logic        finish;

    modport slave (
        input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish_in, gray_data_qtr,
        output gray_ready, gray_data, lbp_ack, gray_addr_hold, lbp_addr_hold, lbp_data_hold,
               gray_count, lbp_count, gray_req_pad, lbp_valid_pad, finish
    );

    modport master (
        output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish_in, gray_data_qtr,
        input  gray_ready, gray_data, lbp_ack, gray_addr_hold, lbp_addr_hold, lbp_data_hold,
               gray_count, lbp_count, gray_req_pad, lbp_valid_pad, finish
    );
endinterface

// File: rtl/io_seq_ctrl.sv
// io_seq_ctrl
// Pad-side sequencer for the pin-limited LBP chip. Latches core transactions, walks the
// quarter selects 0..3 alongside the pad strobes, and rebuilds the 8-bit gray pixel from
// four 2-bit pad quarters (MSB quarter first). The gray-read and LBP-write channels are
// two independent FSMs; a third sticky flag reports end of run.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous active-high reset, clears every output and abandons transactions
//   bus   : io_seq_ctrl_if.slave, all core-side and pad-side signals
module io_seq_ctrl (
    input logic          clk,
    input logic          reset,
    io_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {GIdle, GAddr, GData, GDone} gray_st_e;
    typedef enum logic [1:0] {LIdle, LSend, LAck} lbp_st_e;

    gray_st_e    gray_st_q;
    lbp_st_e     lbp_st_q;
    logic [13:0] gray_addr_q;
    logic [13:0] lbp_addr_q;
    logic [7:0]  lbp_data_q;
    logic [7:0]  gray_data_q;
    logic [5:0]  gray_sh_q;     // first three quarters; the fourth joins on the load
    logic [1:0]  gray_cnt_q;
    logic [1:0]  lbp_cnt_q;
    logic        gray_pad_q;
    logic        lbp_pad_q;
    logic        gray_ready_q;
    logic        lbp_ack_q;
    logic        finish_q;

    // Gray-read channel
    always_ff @(posedge clk) begin
        if (reset) begin
            gray_st_q    <= GIdle;
            gray_addr_q  <= '0;
            gray_data_q  <= '0;
            gray_sh_q    <= '0;
            gray_cnt_q   <= '0;
            gray_pad_q   <= 1'b0;
            gray_ready_q <= 1'b0;
        end else begin
            gray_ready_q <= 1'b0;
            case (gray_st_q)
                GIdle: begin
                    if (bus.gray_req) begin
                        gray_addr_q <= bus.gray_addr;
                        gray_cnt_q  <= 2'd0;
                        gray_pad_q  <= 1'b1;
                        gray_st_q   <= GAddr;
                    end
                end
                GAddr: begin
                    if (gray_cnt_q == 2'd3) begin
                        gray_cnt_q <= 2'd0;
                        gray_pad_q <= 1'b0;
                        gray_st_q  <= GData;
                    end else begin
                        gray_cnt_q <= gray_cnt_q + 2'd1;
                    end
                end
                GData: begin
                    gray_sh_q <= {gray_sh_q[3:0], bus.gray_data_qtr};
                    if (gray_cnt_q == 2'd3) begin
                        gray_data_q  <= {gray_sh_q, bus.gray_data_qtr};
                        gray_cnt_q   <= 2'd0;
                        gray_ready_q <= 1'b1;
                        gray_st_q    <= GDone;
                    end else begin
                        gray_cnt_q <= gray_cnt_q + 2'd1;
                    end
                end
                GDone: begin
                    gray_st_q <= GIdle;
                end
                default: begin
                    gray_st_q <= GIdle;
                end
            endcase
        end
    end

    // LBP-write channel and the sticky finish flag
    always_ff @(posedge clk) begin
        if (reset) begin
            lbp_st_q   <= LIdle;
            lbp_addr_q <= '0;
            lbp_data_q <= '0;
            lbp_cnt_q  <= '0;
            lbp_pad_q  <= 1'b0;
            lbp_ack_q  <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            lbp_ack_q <= 1'b0;
            // Only finish once no result is in flight or being offered.
            if (bus.finish_in && (lbp_st_q == LIdle) && !bus.lbp_valid) begin
                finish_q <= 1'b1;
            end
            case (lbp_st_q)
                LIdle: begin
                    if (bus.lbp_valid) begin
                        lbp_addr_q <= bus.lbp_addr;
                        lbp_data_q <= bus.lbp_data;
                        lbp_cnt_q  <= 2'd0;
                        lbp_pad_q  <= 1'b1;
                        lbp_st_q   <= LSend;
                    end
                end
                LSend: begin
                    if (lbp_cnt_q == 2'd3) begin
                        lbp_cnt_q <= 2'd0;
                        lbp_pad_q <= 1'b0;
                        lbp_ack_q <= 1'b1;
                        lbp_st_q  <= LAck;
                    end else begin
                        lbp_cnt_q <= lbp_cnt_q + 2'd1;
                    end
                end
                LAck: begin
                    lbp_st_q <= LIdle;
                end
                default: begin
                    lbp_st_q <= LIdle;
                end
            endcase
        end
    end

    assign bus.gray_addr_hold = gray_addr_q;
    assign bus.gray_data      = gray_data_q;
    assign bus.gray_count     = gray_cnt_q;
    assign bus.gray_req_pad   = gray_pad_q;
    assign bus.gray_ready     = gray_ready_q;
    assign bus.lbp_addr_hold  = lbp_addr_q;
    assign bus.lbp_data_hold  = lbp_data_q;
    assign bus.lbp_count      = lbp_cnt_q;
    assign bus.lbp_valid_pad  = lbp_pad_q;
    assign bus.lbp_ack        = lbp_ack_q;
    assign bus.finish         = finish_q;

endmodule

// File: tb/tb_io_seq_ctrl.sv
// tb_io_seq_ctrl
// Directed steps followed by a randomized phase, all checked every cycle against a
// timeline model: each channel is described only by the cycle its transaction was accepted,
// and every output follows from the offset of the current cycle from that acceptance.
module tb_io_seq_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    io_seq_ctrl_if bus ();

    io_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state
    bit          g_busy, l_busy;
    int          g_start, l_start;
    logic [13:0] m_gaddr, m_laddr;
    logic [7:0]  m_ldata, m_gdata;
    logic [7:0]  host_pix;
    logic [1:0]  m_q[4];
    bit          m_fin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock: host drives its quarter, model absorbs this cycle's inputs,
    // then outputs of the following cycle are compared at the falling edge.
    task automatic tick();
        int         gd, ld;
        bit         g_idle, l_idle;
        logic [7:0] tmp;
        gd     = g_busy ? cyc - g_start : 0;
        ld     = l_busy ? cyc - l_start : 0;
        g_idle = !g_busy || gd >= 10;
        l_idle = !l_busy || ld >= 6;

        if (!g_idle && gd >= 5 && gd <= 8) begin
            tmp = host_pix >> (2 * (8 - gd));
            bus.gray_data_qtr = tmp[1:0];
        end else begin
            bus.gray_data_qtr = 2'($urandom);
        end

        if (reset) begin
            g_busy  = 0;
            l_busy  = 0;
            m_gaddr = '0;
            m_laddr = '0;
            m_ldata = '0;
            m_gdata = '0;
            m_fin   = 0;
        end else begin
            if (!g_idle && gd >= 5 && gd <= 8) begin
                m_q[gd-5] = bus.gray_data_qtr;
                if (gd == 8) m_gdata = {m_q[0], m_q[1], m_q[2], m_q[3]};
            end
            if (g_idle) g_busy = 0;
            if (g_idle && bus.gray_req) begin
                g_busy  = 1;
                g_start = cyc;
                m_gaddr = bus.gray_addr;
            end
            if (l_idle) l_busy = 0;
            if (bus.finish_in && l_idle && !bus.lbp_valid) m_fin = 1;
            if (l_idle && bus.lbp_valid) begin
                l_busy  = 1;
                l_start = cyc;
                m_laddr = bus.lbp_addr;
                m_ldata = bus.lbp_data;
            end
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);

        gd = (g_busy && cyc - g_start <= 9) ? cyc - g_start : 0;
        ld = (l_busy && cyc - l_start <= 5) ? cyc - l_start : 0;
        check("gray_req_pad", 32'(bus.gray_req_pad), 32'(gd >= 1 && gd <= 4));
        check("gray_count", 32'(bus.gray_count),
              (gd >= 1 && gd <= 4) ? gd - 1 : (gd >= 5 && gd <= 8) ? gd - 5 : 0);
        check("gray_ready", 32'(bus.gray_ready), 32'(gd == 9));
        check("gray_data", 32'(bus.gray_data), 32'(m_gdata));
        check("gray_addr_hold", 32'(bus.gray_addr_hold), 32'(m_gaddr));
        check("lbp_valid_pad", 32'(bus.lbp_valid_pad), 32'(ld >= 1 && ld <= 4));
        check("lbp_count", 32'(bus.lbp_count), (ld >= 1 && ld <= 4) ? ld - 1 : 0);
        check("lbp_ack", 32'(bus.lbp_ack), 32'(ld == 5));
        check("lbp_addr_hold", 32'(bus.lbp_addr_hold), 32'(m_laddr));
        check("lbp_data_hold", 32'(bus.lbp_data_hold), 32'(m_ldata));
        check("finish", 32'(bus.finish), 32'(m_fin));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset         = 1'b1;
        bus.gray_req  = 1'b0;
        bus.gray_addr = '0;
        bus.lbp_valid = 1'b0;
        bus.lbp_addr  = '0;
        bus.lbp_data  = '0;
        bus.finish_in = 1'b0;
        bus.gray_data_qtr = '0;
        host_pix      = 8'h9C;   // quarters 10, 01, 11, 00
        ticks(3);
        reset = 1'b0;
        ticks(2);

        // Single gray read
        bus.gray_req  = 1'b1;
        bus.gray_addr = 14'h2A5C;
        tick();
        bus.gray_req = 1'b0;
        ticks(8);
        check("gray_ready_c9", 32'(bus.gray_ready), 32'd1);
        check("gray_pixel_9c", 32'(bus.gray_data), 32'h9C);
        ticks(2);

        // Single LBP write
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = 14'h3FFF;
        bus.lbp_data  = 8'hB4;
        tick();
        bus.lbp_valid = 1'b0;
        ticks(4);
        check("lbp_ack_c5", 32'(bus.lbp_ack), 32'd1);
        check("lbp_addr_3fff", 32'(bus.lbp_addr_hold), 32'h3FFF);
        check("lbp_data_b4", 32'(bus.lbp_data_hold), 32'hB4);
        ticks(2);

        // Concurrent transactions
        host_pix      = 8'h5A;
        bus.gray_req  = 1'b1;
        bus.gray_addr = 14'h1234;
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = 14'h0ABC;
        bus.lbp_data  = 8'h3C;
        tick();
        bus.gray_req  = 1'b0;
        bus.lbp_valid = 1'b0;
        ticks(10);

        // Inputs ignored while busy
        bus.gray_req  = 1'b1;
        bus.gray_addr = 14'h2222;
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = 14'h1111;
        bus.lbp_data  = 8'h77;
        tick();
        bus.gray_addr = 14'h0001;
        bus.lbp_addr  = 14'h0002;
        bus.lbp_data  = 8'h03;
        for (int i = 0; i < 4; i++) begin
            bus.lbp_valid = i[0];
            tick();
        end
        bus.gray_req  = 1'b0;
        bus.lbp_valid = 1'b0;
        check("gray_hold_kept", 32'(bus.gray_addr_hold), 32'h2222);
        ticks(6);

        // Reset in cycle 3 of a gray read
        bus.gray_req  = 1'b1;
        bus.gray_addr = 14'h0F0F;
        tick();
        bus.gray_req = 1'b0;
        ticks(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_gray_addr_hold", 32'(bus.gray_addr_hold), 32'd0);
        ticks(6);
        check("rst_no_ready", 32'(bus.gray_ready), 32'd0);
        bus.gray_req  = 1'b1;
        bus.gray_addr = 14'h3A01;
        tick();
        bus.gray_req = 1'b0;
        ticks(10);

        // Finish raised while a result is being sent
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = 14'h0100;
        bus.lbp_data  = 8'hE1;
        tick();
        bus.lbp_valid = 1'b0;
        bus.finish_in = 1'b1;
        ticks(4);
        check("finish_low_at_ack", 32'(bus.finish), 32'd0);
        tick();
        check("finish_low_back_idle", 32'(bus.finish), 32'd0);
        tick();
        check("finish_set", 32'(bus.finish), 32'd1);
        bus.finish_in = 1'b0;
        ticks(3);
        check("finish_sticky", 32'(bus.finish), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            reset         = ($urandom_range(0, 119) == 0);
            bus.gray_req  = ($urandom_range(0, 2) == 0);
            bus.gray_addr = 14'($urandom);
            bus.lbp_valid = ($urandom_range(0, 2) == 0);
            bus.lbp_addr  = 14'($urandom);
            bus.lbp_data  = 8'($urandom);
            bus.finish_in = ($urandom_range(0, 39) == 0);
            host_pix      = 8'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/io_seq_ctrl.md
# io_seq_ctrl

Pad-side sequencer for the pin-limited LBP chip. It sits between the LBP core and the quarter-split multiplexer, which slices a 14-bit address into a 2-bit plus three 4-bit quarters and an 8-bit result into four 2-bit quarters. This block does three things:
- latches each core transaction;
- drives `gray_count` and `lbp_count` through 0..3 together with the pad strobes;
- reassembles the 8-bit gray pixel that returns over 2-bit pads.

The gray-read channel and the LBP-write channel run independently and concurrently.

## Interface
Parameters: none. All widths are fixed: address 14 bits, data 8 bits, quarter count 2 bits.

- `clk`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `gray_req`  in  1  core requests the pixel at `gray_addr`
- `gray_addr`  in  14  core pixel address, sampled only on acceptance
- `gray_ready`  out  1  one-cycle pulse: `gray_data` is valid
- `gray_data`  out  8  reassembled pixel, held until the next `gray_ready`
- `lbp_valid`  in  1  core offers the result `lbp_data` for `lbp_addr`
- `lbp_addr`  in  14  result address, sampled only on acceptance
- `lbp_data`  in  8  result value, sampled only on acceptance
- `lbp_ack`  out  1  one-cycle pulse: all four result quarters have been sent
- `finish_in`  in  1  core signals the last result has been issued
- `gray_addr_hold`  out  14  latched gray address, to the splitter
- `lbp_addr_hold`  out  14  latched result address, to the splitter
- `lbp_data_hold`  out  8  latched result data, to the splitter
- `gray_count`  out  2  quarter select for the gray address
- `lbp_count`  out  2  quarter select for the result address and data
- `gray_req_pad`  out  1  high while gray address quarters are on the pads
- `gray_data_qtr`  in  2  returned pixel quarter from the host, MSB quarter first
- `lbp_valid_pad`  out  1  high while result quarters are on the pads
- `finish`  out  1  sticky end-of-run flag to the pads

## Operation
**Gray FSM: G_IDLE → G_ADDR → G_DATA → G_DONE → G_IDLE**
- **G_IDLE:** if `gray_req`=1, latch `gray_addr` into `gray_addr_hold`, clear `gray_count` to 0, and go to G_ADDR.
- **G_ADDR:** `gray_req_pad`=1. `gray_count` steps 0,1,2,3, one value per cycle. After count 3, go to G_DATA with the count cleared to 0.
- **G_DATA:** `gray_req_pad`=0. `gray_count` steps 0..3. Each cycle, shift `gray_data_qtr` into a shift register from the LSB end: `sh <= {sh[5:0], gray_data_qtr}`. After 4 quarters, the first quarter sits in bits [7:6]. At count 3, load the final value into `gray_data` and go to G_DONE.
- **G_DONE:** `gray_ready`=1 for one cycle, `gray_count`=0, return to G_IDLE. The core drops `gray_req` in response to `gray_ready`; a request still high in G_IDLE starts a new transaction.
- `gray_req` and `gray_addr` are ignored outside G_IDLE.

**LBP FSM: L_IDLE → L_SEND → L_ACK → L_IDLE**
- **L_IDLE:** if `lbp_valid`=1, latch `lbp_addr` and `lbp_data`, clear `lbp_count` to 0, and go to L_SEND.
- **L_SEND:** `lbp_valid_pad`=1. `lbp_count` steps 0..3. After count 3, go to L_ACK.
- **L_ACK:** `lbp_ack`=1 for one cycle, `lbp_count`=0, return to L_IDLE.
- `lbp_valid`, `lbp_addr` and `lbp_data` are ignored outside L_IDLE.

**Finish**
- `finish` is set when `finish_in`=1, the LBP FSM is in L_IDLE, and `lbp_valid`=0.
- Once set, `finish` stays high until reset.

**Concurrency**
- The two FSMs share no state. Simultaneous acceptance on both channels is legal, and the two counts advance independently.

## Timing
**Reset** (synchronous; takes effect mid-transaction as well): both FSMs go to idle. Every output is 0: counts, pad strobes, `gray_ready`, `lbp_ack`, `finish`, `gray_data`, and all hold registers. Any partially sent or partially received transaction is abandoned with no ack.

**Gray read**, with `gray_req` sampled high at edge E0:
- cycles 1–4: G_ADDR, counts 0..3
- cycles 5–8: G_DATA, one quarter sampled per cycle
- cycle 9: `gray_ready`=1
- Latency is 9 cycles; a new request is accepted at the earliest in cycle 10.

**LBP write**, with `lbp_valid` sampled high at E0:
- cycles 1–4: L_SEND
- cycle 5: `lbp_ack`=1
- Next acceptance at the earliest in cycle 6, so throughput is 1 result per 6 cycles.

**Hold registers** are stable from the cycle after acceptance until the next acceptance.

**Idle values:** counts are 0 in every idle or done/ack state.

**Pulse width:** `gray_ready` and `lbp_ack` are never high for more than one consecutive cycle.

## Test plan
- **Single gray read.** `gray_req` with `gray_addr`=14'h2A5C; host returns quarters 2'b10, 2'b01, 2'b11, 2'b00.
  Required: `gray_req_pad` high in cycles 1–4 with `gray_count` 0..3; `gray_ready` in cycle 9 with `gray_data`=8'h9C.
- **Single LBP write.** `lbp_valid` with `lbp_addr`=14'h3FFF, `lbp_data`=8'hB4.
  Required: `lbp_valid_pad` high in cycles 1–4 with `lbp_count` 0..3; `lbp_ack` in cycle 5; holds equal 14'h3FFF / 8'hB4.
- **Concurrent transactions.** `gray_req` and `lbp_valid` in the same cycle.
  Required: `lbp_ack` in cycle 5 and `gray_ready` in cycle 9, with no interference between counts.
- **Inputs ignored while busy.** Change `gray_addr` to 14'h0001 and toggle `lbp_valid` mid-transaction.
  Required: holds unchanged; no extra ack or ready.
- **Reset mid-transaction.** Assert reset in cycle 3 of a gray read.
  Required: all outputs 0 in the next cycle; no `gray_ready`; a fresh request completes normally.
- **Finish.** `finish_in`=1 while L_SEND is in progress.
  Required: `finish` rises only after `lbp_ack`, once the FSM is back in L_IDLE, and stays high.
